// File: rtl/lfsr_random_source_pkg.sv
// Shared definitions for the LFSR random source: default feedback masks,
// the lockup-escape seed and the packer FSM state encoding.
package lfsr_random_source_pkg;

  // Packer FSM: FILL collects bits, HOLD presents a word until it is taken.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_e;

  // Loaded whenever the LFSR would be stuck at zero or a zero seed is written.
  localparam logic [31:0] LOCKUP_SEED_DEFAULT = 32'h0000_BEEF;

  // Maximal-length Fibonacci masks for the widths the game logic uses.
  localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_W24 = 32'h00E1_0000;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // Default feedback mask for a given state width; unsupported widths
  // return zero so the instantiating module must supply its own mask.
  function automatic logic [31:0] default_taps(input int w);
    logic [31:0] taps;
    case (w)
      8:       taps = TAPS_W8;
      16:      taps = TAPS_W16;
      24:      taps = TAPS_W24;
      32:      taps = TAPS_W32;
      default: taps = 32'h0000_0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_random_source_if.sv
// Output word channel of the random source.
// Handshake: out_valid/out_data come from the producer; a word transfers on
// every rising clk edge where out_valid and out_ready are both high. Once
// out_valid is raised it stays high and out_data stays stable until that
// transfer; out_ready while out_valid is low has no effect.
interface lfsr_random_source_if #(
  parameter int OUT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/lfsr_random_source_lfsr_core.sv
// Free-running Fibonacci LFSR with entropy mixing, lockup escape and reseed.
// fb is the bit shifted in this cycle; fb_ok drops on the lockup-escape
// cycle so the consumer does not collect the forced bit.
module lfsr_core
  import lfsr_random_source_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
  parameter logic [WIDTH-1:0] LOCKUP_SEED = WIDTH'(LOCKUP_SEED_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entropy,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value,
  output logic             fb,
  output logic             fb_ok,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  // Next state: reseed beats the step; an all-zero state is replaced by the
  // lockup seed and its feedback bit is reported as 0 and not collectable.
  always_comb begin
    fb      = (^(state_q & TAPS)) ^ entropy;
    fb_ok   = 1'b1;
    state_d = {state_q[WIDTH-2:0], fb};
    if (state_q == '0) begin
      fb      = 1'b0;
      fb_ok   = 1'b0;
      state_d = LOCKUP_SEED;
    end
    if (seed_load) begin
      state_d = (seed_value == '0) ? LOCKUP_SEED : seed_value;
    end
  end

  // State register; steps every cycle regardless of downstream back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/lfsr_random_source.sv
// Pseudorandom word source: packs LFSR bits into OUT_W-bit words, rejects
// words at or above a nonzero limit, and offers accepted words over a
// valid/ready channel. rst is asynchronous, active low, and is expected to
// be released synchronously to clk by the surrounding reset logic.
module lfsr_random_source
  import lfsr_random_source_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               OUT_W       = 8,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
  parameter logic [WIDTH-1:0] LOCKUP_SEED = WIDTH'(LOCKUP_SEED_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 entropy,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_value,
  input  logic [OUT_W-1:0]     limit,
  output logic [7:0]           reject_cnt,
  lfsr_random_source_if.master out_if,
  output fsm_e                 dbg_state,
  output logic [WIDTH-1:0]     dbg_lfsr
);

  localparam int               CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);

  logic             lfsr_fb;
  logic             lfsr_fb_ok;
  logic [WIDTH-1:0] lfsr_state;

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [OUT_W-1:0] shift_q, shift_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [7:0]       rej_q, rej_d;
  logic [OUT_W-1:0] candidate;

  lfsr_core #(
    .WIDTH      (WIDTH),
    .TAPS       (TAPS),
    .SEED       (SEED),
    .LOCKUP_SEED(LOCKUP_SEED)
  ) u_lfsr_core (
    .clk       (clk),
    .rst       (rst),
    .entropy   (entropy),
    .seed_load (seed_load),
    .seed_value(seed_value),
    .fb        (lfsr_fb),
    .fb_ok     (lfsr_fb_ok),
    .state     (lfsr_state)
  );

  // Packer FSM next state: reseed clears everything and drops any pending
  // word; FILL collects one bit per valid fb and checks the limit on the
  // last bit; HOLD waits for the consumer.
  always_comb begin
    fsm_d     = fsm_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    rej_d     = rej_q;
    candidate = {shift_q[OUT_W-2:0], lfsr_fb};
    if (seed_load) begin
      fsm_d     = FILL;
      bit_cnt_d = '0;
      shift_d   = '0;
      valid_d   = 1'b0;
      rej_d     = '0;
    end else begin
      case (fsm_q)
        FILL: begin
          if (lfsr_fb_ok) begin
            shift_d = candidate;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              if ((limit != '0) && (candidate >= limit)) begin
                rej_d = (rej_q == 8'hFF) ? rej_q : rej_q + 8'd1;
              end else begin
                data_d  = candidate;
                valid_d = 1'b1;
                fsm_d   = HOLD;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_if.out_ready) begin
            valid_d   = 1'b0;
            bit_cnt_d = '0;
            fsm_d     = FILL;
          end
        end
      endcase
    end
  end

  // Packer, output and reject-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q     <= FILL;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      rej_q     <= '0;
    end else begin
      fsm_q     <= fsm_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      rej_q     <= rej_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign reject_cnt       = rej_q;
  assign dbg_state        = fsm_q;
  assign dbg_lfsr         = lfsr_state;

endmodule

// File: tb/tb_lfsr_random_source.sv
// Testbench for lfsr_random_source: directed scenarios plus randomized
// traffic checked against a bit-list reference model of the source.
module tb_lfsr_random_source;
  import lfsr_random_source_pkg::*;

  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'h0001;
  localparam logic [15:0] LOCK = 16'hBEEF;
  localparam int          OW   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        entropy = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_value = '0;
  logic [7:0]  limit = '0;
  logic [7:0]  reject_cnt;
  fsm_e        dbg_state;
  logic [15:0] dbg_lfsr;

  lfsr_random_source_if #(.OUT_W(OW)) bus ();

  lfsr_random_source #(.WIDTH(16), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .entropy   (entropy),
    .seed_load (seed_load),
    .seed_value(seed_value),
    .limit     (limit),
    .reject_cnt(reject_cnt),
    .out_if    (bus),
    .dbg_state (dbg_state),
    .dbg_lfsr  (dbg_lfsr)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: LFSR value, bits gathered for the current word,
  // presented word, reject count, and queue of words awaiting transfer
  logic [15:0] m_state;
  bit          m_bits[$];
  logic        m_valid;
  logic [7:0]  m_data;
  logic [7:0]  m_rej;
  logic [7:0]  exp_q[$];

  task automatic model_reset();
    m_state = SEED;
    m_bits.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_rej   = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit fb;
    bit stuck;
    int cand;
    if (!rst) begin
      model_reset();
      return;
    end
    if (seed_load) begin
      m_state = (seed_value == 16'd0) ? LOCK : seed_value;
      if (m_valid) void'(exp_q.pop_back());
      m_valid = 1'b0;
      m_bits.delete();
      m_rej = '0;
      return;
    end
    stuck = (m_state == 16'd0);
    fb = (($countones(m_state & TAPS) % 2) != 0) ^ entropy;
    m_state = stuck ? LOCK : 16'((int'(m_state) * 2 + int'(fb)) % 65536);
    if (m_valid) begin
      if (bus.out_ready) m_valid = 1'b0;
    end else if (!stuck) begin
      m_bits.push_back(fb);
      if (m_bits.size() == OW) begin
        cand = 0;
        foreach (m_bits[i]) cand = cand * 2 + int'(m_bits[i]);
        m_bits.delete();
        if (limit != 8'd0 && cand >= int'(limit)) begin
          m_rej = (m_rej == 8'd255) ? m_rej : m_rej + 8'd1;
        end else begin
          m_data  = 8'(cand);
          m_valid = 1'b1;
          exp_q.push_back(8'(cand));
        end
      end
    end
  endtask

  // one clock: model sees the inputs present at the rising edge, bench
  // resumes on the falling edge where outputs are sampled and inputs driven
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
    checks++; if (reject_cnt !== 8'd0) begin failures++; $display("FAIL reset_rej got=%0d exp=0", reject_cnt); end
    checks++; if (dbg_lfsr !== SEED) begin failures++; $display("FAIL reset_lfsr got=%h exp=%h", dbg_lfsr, SEED); end
    checks++; if (dbg_state !== FILL) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, FILL); end
  endtask

  task automatic test_first_word();
    entropy = 1'b0;
    limit = 8'd0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if (bus.out_valid !== (c == 8)) begin
        failures++; $display("FAIL first_latency cycle=%0d got=%b exp=%b", c, bus.out_valid, (c == 8));
      end
    end
    checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL first_data got=%h exp=00", bus.out_data); end
    checks++; if (dbg_lfsr !== 16'h0100) begin failures++; $display("FAIL first_lfsr got=%h exp=0100", dbg_lfsr); end
    checks++; if (dbg_lfsr !== m_state) begin failures++; $display("FAIL first_model_lfsr got=%h exp=%h", dbg_lfsr, m_state); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] d0;
    logic [7:0] w;
    int n;
    d0 = bus.out_data;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== d0) begin
        failures++; $display("FAIL bp_hold i=%0d got v=%b d=%h exp v=1 d=%h", i, bus.out_valid, bus.out_data, d0);
      end
      checks++;
      if (dbg_lfsr !== m_state) begin
        failures++; $display("FAIL bp_lfsr_step i=%0d got=%h exp=%h", i, dbg_lfsr, m_state);
      end
    end
    bus.out_ready = 1'b1;
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL bp_handshake got=%h exp=(no word)", bus.out_data);
    end else begin
      w = exp_q.pop_front();
      if (bus.out_data !== w) begin failures++; $display("FAIL bp_handshake got=%h exp=%h", bus.out_data, w); end
    end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drop_valid got=%b exp=0", bus.out_valid); end
    n = 0;
    while (!bus.out_valid && n < 20) begin tick(); n++; end
    checks++; if (n != 8) begin failures++; $display("FAIL bp_next_latency got=%0d exp=8", n); end
    checks++; if (bus.out_data !== m_data) begin failures++; $display("FAIL bp_next_data got=%h exp=%h", bus.out_data, m_data); end
  endtask

  task automatic test_limit_one();
    int acc = 0;
    int cyc = 0;
    bit skip_first;
    logic [7:0] w;
    limit = 8'd1;
    bus.out_ready = 1'b1;
    skip_first = bus.out_valid;
    while (acc < 2 && cyc < 25000) begin
      checks++;
      if ({bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr} !== {m_valid, m_data, m_rej, m_state}) begin
        failures++;
        $display("FAIL lim1_cycle t=%0t got v=%b d=%h rej=%0d lfsr=%h exp v=%b d=%h rej=%0d lfsr=%h", $time,
                 bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr, m_valid, m_data, m_rej, m_state);
      end
      entropy = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL lim1_handshake got=%h exp=(no word)", bus.out_data);
        end else begin
          w = exp_q.pop_front();
          if (bus.out_data !== w) begin failures++; $display("FAIL lim1_handshake got=%h exp=%h", bus.out_data, w); end
        end
        if (skip_first) begin
          skip_first = 1'b0;
        end else begin
          checks++;
          if (bus.out_data !== 8'h00) begin failures++; $display("FAIL lim1_zero got=%h exp=00", bus.out_data); end
          acc++;
        end
      end
      tick();
      cyc++;
    end
    checks++; if (acc < 2) begin failures++; $display("FAIL lim1_budget got=%0d words exp=2", acc); end
    bus.out_ready = 1'b0;
    entropy = 1'b0;
  endtask

  task automatic test_seed_zero();
    int n = 0;
    logic [7:0] w;
    limit = 8'd0;
    entropy = 1'b0;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL seed_reach_hold got=%b exp=1", bus.out_valid); end
    seed_load = 1'b1;
    seed_value = 16'h0000;
    bus.out_ready = 1'b1;
    tick();
    seed_load = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (dbg_lfsr !== LOCK) begin failures++; $display("FAIL seed_lfsr got=%h exp=%h", dbg_lfsr, LOCK); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL seed_valid got=%b exp=0", bus.out_valid); end
    checks++; if (reject_cnt !== 8'd0) begin failures++; $display("FAIL seed_rej got=%0d exp=0", reject_cnt); end
    checks++; if (dbg_state !== FILL) begin failures++; $display("FAIL seed_state got=%0d exp=%0d", dbg_state, FILL); end
    for (int i = 0; i < 200; i++) begin
      checks++;
      if ({bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr} !== {m_valid, m_data, m_rej, m_state}) begin
        failures++;
        $display("FAIL seed_cycle t=%0t got v=%b d=%h rej=%0d lfsr=%h exp v=%b d=%h rej=%0d lfsr=%h", $time,
                 bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr, m_valid, m_data, m_rej, m_state);
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL seed_handshake got=%h exp=(no word)", bus.out_data);
        end else begin
          w = exp_q.pop_front();
          if (bus.out_data !== w) begin failures++; $display("FAIL seed_handshake got=%h exp=%h", bus.out_data, w); end
        end
      end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int n = 0;
    limit = 8'd0;
    bus.out_ready = 1'b0;
    seed_load = 1'b1;
    seed_value = 16'hACE1;
    tick();
    seed_load = 1'b0;
    repeat (5) tick();
    checks++; if (dbg_state !== FILL) begin failures++; $display("FAIL ar_fill_state got=%0d exp=%0d", dbg_state, FILL); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr} !== {1'b0, 8'h00, 8'h00, SEED}) begin
      failures++; $display("FAIL ar_fill_outputs got v=%b d=%h rej=%0d lfsr=%h exp v=0 d=00 rej=0 lfsr=%h",
                           bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr, SEED);
    end
    @(negedge clk);
    rst = 1'b1;
    seed_load = 1'b1;
    seed_value = 16'h5A3C;
    tick();
    seed_load = 1'b0;
    while (!bus.out_valid && n < 40) begin tick(); n++; end
    checks++; if (dbg_state !== HOLD) begin failures++; $display("FAIL ar_hold_state got=%0d exp=%0d", dbg_state, HOLD); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr, dbg_state} !== {1'b0, 8'h00, 8'h00, SEED, FILL}) begin
      failures++; $display("FAIL ar_hold_outputs got v=%b d=%h rej=%0d lfsr=%h st=%0d exp v=0 d=00 rej=0 lfsr=%h st=0",
                           bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr, dbg_state, SEED);
    end
    @(negedge clk);
    limit = 8'd100;
    rst = 1'b1;
  endtask

  task automatic test_random();
    int acc = 0;
    int cyc = 0;
    logic [7:0] w;
    limit = 8'd100;
    while (acc < 1500 && cyc < 60000) begin
      checks++;
      if ({bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr} !== {m_valid, m_data, m_rej, m_state}) begin
        failures++;
        $display("FAIL rand_cycle t=%0t got v=%b d=%h rej=%0d lfsr=%h exp v=%b d=%h rej=%0d lfsr=%h", $time,
                 bus.out_valid, bus.out_data, reject_cnt, dbg_lfsr, m_valid, m_data, m_rej, m_state);
      end
      entropy = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 499) == 0);
      seed_value = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
      if (bus.out_valid && bus.out_ready && !seed_load) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_handshake got=%h exp=(no word)", bus.out_data);
        end else begin
          w = exp_q.pop_front();
          if (bus.out_data !== w) begin failures++; $display("FAIL rand_handshake got=%h exp=%h", bus.out_data, w); end
        end
        checks++;
        if (bus.out_data >= 8'd100) begin failures++; $display("FAIL rand_range got=%0d exp=<100", bus.out_data); end
        acc++;
      end
      tick();
      cyc++;
    end
    seed_load = 1'b0;
    checks++; if (acc < 1500) begin failures++; $display("FAIL rand_budget got=%0d words exp=1500", acc); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_word();
    test_back_pressure();
    test_limit_one();
    test_seed_zero();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // last-resort bound on total run time
  initial begin
    #1200000;
    $display("FAIL watchdog t=%0t exp=finish before limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
